spi_reg_writer: RTL and testbench

Controller-side sequencer for the chip's SPI register peripheral (enable-out, enable-PWM, PWM-duty registers). Two on-chip requesters queue register writes. A round-robin arbiter picks one, and the block serialises it as a 16-bit SPI write frame on ncs/sclk/copi. The block also keeps a shadow copy of the five peripheral byte registers so the rest of the design can read back the last-written configuration without a read transaction.

---
 rtl/spi_reg_writer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// SPI register write sequencer: round-robin arbitration of two requesters, 16-bit write frames, shadow copies.
// Optional boot-time clearing of all five registers is compiled in with SPI_REG_WRITER_BOOT_INIT_EN.
module spi_reg_writer #(
  parameter int CLK_DIV_HALF = 50,
  parameter int GAP          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_addr,
  input  logic [7:0]  req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_addr,
  input  logic [7:0]  req1_data,
  output logic        ncs,
  output logic        sclk,
  output logic        copi,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        grant_id,
  output logic [15:0] shadow_en_out,
  output logic [15:0] shadow_en_pwm,
  output logic [7:0]  shadow_pwm_duty
);

  localparam int CNT_MAX = (2 * CLK_DIV_HALF > GAP) ? 2 * CLK_DIV_HALF : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLK_DIV_HALF - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(2 * CLK_DIV_HALF - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP - 2);
  localparam logic [CW-1:0] SCLK_RISE = CW'(CLK_DIV_HALF / 2);
  localparam logic [CW-1:0] SCLK_FALL = CW'(3 * CLK_DIV_HALF / 2);
  localparam logic [6:0]    ADDR_MAX  = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
    , ST_INIT = 3'd5
`endif
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [3:0]      bit_r, bit_s;
  logic [15:0]     sh_r, sh_s;
  logic [2:0]      addr_r, addr_s;
  logic [7:0]      data_r, data_s;
  logic            last_r, last_s;
  logic            gid_r, gid_s;
  logic            rdy0_r, rdy0_s;
  logic            rdy1_r, rdy1_s;
  logic            ncs_r, ncs_s;
  logic            sclk_r, sclk_s;
  logic            copi_r, copi_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            err_r, err_s;
  logic            upd_s;
  logic            frame_s;
  logic [15:0]     en_out_r, en_pwm_r;
  logic [7:0]      duty_r;
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
  logic            init_act_r, init_act_s;
  logic [2:0]      init_addr_r, init_addr_s;
`endif

  // Acceptance and round-robin choice; readies are one-hot so at most one side is taken.
  logic       acc0_s, acc1_s, acc_s, take_s, any_s, gsel_s;
  logic [6:0] acc_addr_s;
  logic [7:0] acc_data_s;

  assign acc0_s     = req0_valid & rdy0_r;
  assign acc1_s     = req1_valid & rdy1_r & ~acc0_s;
  assign acc_s      = acc0_s | acc1_s;
  assign take_s     = (state_r == ST_IDLE) & acc_s;
  assign acc_addr_s = acc1_s ? req1_addr : req0_addr;
  assign acc_data_s = acc1_s ? req1_data : req0_data;
  assign any_s      = req0_valid | req1_valid;
  assign gsel_s     = (req0_valid & req1_valid) ? ~last_r : ~req0_valid;

  // Next-state logic; output values are derived from the next state so every output is a flop.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    sh_s    = sh_r;
    addr_s  = addr_r;
    data_s  = data_r;
    last_s  = last_r;
    gid_s   = gid_r;
    err_s   = 1'b0;
    done_s  = 1'b0;
    upd_s   = 1'b0;
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
    init_act_s  = init_act_r;
    init_addr_s = init_addr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          last_s = acc1_s;
          gid_s  = acc1_s;
          if (acc_addr_s <= ADDR_MAX) begin
            addr_s  = acc_addr_s[2:0];
            data_s  = acc_data_s;
            sh_s    = {1'b1, acc_addr_s, acc_data_s};
            cnt_s   = CNT_ZERO;
            state_s = ST_SETUP;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == HALF_END) begin
          cnt_s   = CNT_ZERO;
          bit_s   = 4'd0;
          state_s = ST_SHIFT;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == SLOT_END) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 4'd15) begin
            state_s = ST_HOLD;
          end else begin
            bit_s = bit_r + 4'd1;
            sh_s  = {sh_r[14:0], 1'b0};
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HALF_END) begin
          cnt_s   = CNT_ZERO;
          done_s  = 1'b1;
          upd_s   = 1'b1;
          state_s = ST_GAP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        // The last ncs-high cycle is spent in IDLE with ready already up.
        if (cnt_r == GAP_END) begin
          cnt_s = CNT_ZERO;
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
          if (init_act_r) begin
            if (init_addr_r == 3'd4) begin
              init_act_s = 1'b0;
              state_s    = ST_IDLE;
            end else begin
              init_addr_s = init_addr_r + 3'd1;
              state_s     = ST_INIT;
            end
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
      ST_INIT: begin
        addr_s  = init_addr_r;
        data_s  = 8'h00;
        sh_s    = {1'b1, 4'b0000, init_addr_r, 8'h00};
        cnt_s   = CNT_ZERO;
        state_s = ST_SETUP;
      end
`endif
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    frame_s = (state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_HOLD);
    ncs_s   = ~frame_s;
    copi_s  = frame_s & sh_s[15];
    sclk_s  = (state_s == ST_SHIFT) && (cnt_s >= SCLK_RISE) && (cnt_s < SCLK_FALL);
    busy_s  = (state_s != ST_IDLE) || take_s;
    rdy0_s  = (state_s == ST_IDLE) && !take_s && any_s && !gsel_s;
    rdy1_s  = (state_s == ST_IDLE) && !take_s && any_s && gsel_s;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
      state_r     <= ST_INIT;
      init_act_r  <= 1'b1;
      init_addr_r <= 3'd0;
`else
      state_r     <= ST_IDLE;
`endif
      cnt_r  <= CNT_ZERO;
      bit_r  <= 4'd0;
      sh_r   <= 16'h0000;
      addr_r <= 3'd0;
      data_r <= 8'h00;
      last_r <= 1'b1;
      gid_r  <= 1'b0;
      rdy0_r <= 1'b0;
      rdy1_r <= 1'b0;
      ncs_r  <= 1'b1;
      sclk_r <= 1'b0;
      copi_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
      init_act_r  <= init_act_s;
      init_addr_r <= init_addr_s;
`endif
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      sh_r    <= sh_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      last_r  <= last_s;
      gid_r   <= gid_s;
      rdy0_r  <= rdy0_s;
      rdy1_r  <= rdy1_s;
      ncs_r   <= ncs_s;
      sclk_r  <= sclk_s;
      copi_r  <= copi_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Shadow bytes follow the frame that just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_r <= 16'h0000;
      en_pwm_r <= 16'h0000;
      duty_r   <= 8'h00;
    end else if (upd_s) begin
      case (addr_r)
        3'd0:    en_out_r[7:0]  <= data_r;
        3'd1:    en_out_r[15:8] <= data_r;
        3'd2:    en_pwm_r[7:0]  <= data_r;
        3'd3:    en_pwm_r[15:8] <= data_r;
        3'd4:    duty_r         <= data_r;
        default: duty_r         <= duty_r;
      endcase
    end else begin
      duty_r <= duty_r;
    end
  end

  assign req0_ready      = rdy0_r;
  assign req1_ready      = rdy1_r;
  assign ncs             = ncs_r;
  assign sclk            = sclk_r;
  assign copi            = copi_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign err             = err_r;
  assign grant_id        = gid_r;
  assign shadow_en_out   = en_out_r;
  assign shadow_en_pwm   = en_pwm_r;
  assign shadow_pwm_duty = duty_r;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed self-checking bench for spi_reg_writer (CLK_DIV_HALF=4, GAP=4).
// Also checks the boot-init frames when built with SPI_REG_WRITER_BOOT_INIT_EN.
module tb_spi_reg_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [6:0]  req0_addr = 7'd0, req1_addr = 7'd0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        ncs, sclk, copi, busy, done, err, grant_id;
  logic [15:0] shadow_en_out, shadow_en_pwm;
  logic [7:0]  shadow_pwm_duty;

  int checks = 0;
  int errors = 0;

  spi_reg_writer #(.CLK_DIV_HALF(4), .GAP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .ncs(ncs), .sclk(sclk), .copi(copi), .busy(busy), .done(done), .err(err), .grant_id(grant_id),
    .shadow_en_out(shadow_en_out), .shadow_en_pwm(shadow_en_pwm), .shadow_pwm_duty(shadow_pwm_duty)
  );

  always #5 clk = ~clk;

  // Bus monitor: sampled on the falling edge, away from output updates.
  int          cyc = 0;
  int          rises = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, ready_cnt = 0;
  int          low_run = 0, last_low = 0, high_run = 0, last_high = 0;
  logic [15:0] cap_word = 16'h0000;
  logic        prev_sclk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    if (sclk && !prev_sclk) begin
      cap_word <= {cap_word[14:0], copi};
      rises    <= rises + 1;
    end
    if (!ncs) begin
      low_run <= low_run + 1;
      if (high_run != 0) last_high <= high_run;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
      if (low_run != 0) last_low <= low_run;
      low_run <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
    if (req0_ready || req1_ready) ready_cnt <= ready_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(output int id, output int acc_cyc);
    id = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin id = 0; break; end
      if (req1_valid && req1_ready) begin id = 1; break; end
    end
    acc_cyc = cyc;
    check("accept_seen", (id >= 0), 1'b1);
    if (id == 0) begin
      @(posedge clk); #1 req0_valid = 1'b0;
    end else if (id == 1) begin
      @(posedge clk); #1 req1_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic boot_frames();
`ifdef SPI_REG_WRITER_BOOT_INIT_EN
    for (int k = 0; k < 5; k++) begin
      wait_done();
      repeat (2) @(negedge clk);
      check("boot_word", cap_word, 32'h8000 | (k << 8));
      check("boot_grant", grant_id, 1'b0);
    end
    repeat (4) @(negedge clk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    boot_frames();
  endtask

  initial begin
    int id, c1, c2, snap_r, snap_d, snap_e;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_copi", copi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_grant", grant_id, 1'b0);
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_shadows", {shadow_en_out, shadow_en_pwm}, 32'h0);
    check("rst_duty", shadow_pwm_duty, 8'h00);
    rst_n = 1'b1;
    boot_frames();
    check("no_ready_before_idle", ready_cnt, 0);

    // Single write plus a queued back-to-back write
    snap_r = rises; snap_d = done_cnt;
    req0_addr = 7'd4; req0_data = 8'hA5; req0_valid = 1'b1;
    wait_accept(id, c1);
    check("single_id", id, 0);
    req0_addr = 7'd3; req0_data = 8'h5A; req0_valid = 1'b1;
    @(negedge clk);
    check("t1_ncs_low", ncs, 1'b0);
    check("t1_busy", busy, 1'b1);
    check("busy_ready_low", req0_ready, 1'b0);
    wait_done();
    check("done_ncs_high", ncs, 1'b1);
    repeat (2) @(negedge clk);
    check("single_word", cap_word, 16'h84A5);
    check("single_rises", rises - snap_r, 16);
    check("single_ncs_low", last_low, 136);
    check("single_done_cnt", done_cnt - snap_d, 1);
    check("single_duty", shadow_pwm_duty, 8'hA5);
    wait_accept(id, c2);
    check("period", c2 - c1, 140);
    wait_done();
    repeat (2) @(negedge clk);
    check("second_word", cap_word, 16'h835A);
    check("second_pwm", shadow_en_pwm, 16'h5A00);
    check("gap_high", last_high, 4);

    // Contention after reset, then alternation
    do_reset();
    req0_addr = 7'd0; req0_data = 8'h11; req0_valid = 1'b1;
    req1_addr = 7'd2; req1_data = 8'h22; req1_valid = 1'b1;
    wait_accept(id, c1);
    check("cont_first_id", id, 0);
    check("cont_first_grant", grant_id, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    check("cont_first_word", cap_word, 16'h8011);
    wait_accept(id, c1);
    check("cont_second_id", id, 1);
    check("cont_second_grant", grant_id, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    check("cont_second_word", cap_word, 16'h8222);
    check("cont_en_out", shadow_en_out, 16'h0011);
    check("cont_en_pwm", shadow_en_pwm, 16'h0022);
    req0_addr = 7'd1; req0_data = 8'h33; req0_valid = 1'b1;
    req1_addr = 7'd3; req1_data = 8'h44; req1_valid = 1'b1;
    wait_accept(id, c1);
    check("cont_third_id", id, 0);
    wait_done();
    wait_accept(id, c1);
    check("cont_fourth_id", id, 1);
    wait_done();
    repeat (2) @(negedge clk);
    check("cont_en_out2", shadow_en_out, 16'h3311);
    check("cont_en_pwm2", shadow_en_pwm, 16'h4422);

    // Invalid address
    snap_r = rises; snap_e = err_cnt;
    req1_addr = 7'd7; req1_data = 8'h99; req1_valid = 1'b1;
    wait_accept(id, c1);
    check("inv_id", id, 1);
    req0_addr = 7'd4; req0_data = 8'h77; req0_valid = 1'b1;
    @(negedge clk);
    check("inv_err_t1", err, 1'b1);
    check("inv_ncs", ncs, 1'b1);
    check("inv_ready_t1", req0_ready, 1'b0);
    wait_accept(id, c2);
    check("inv_ready_t2", c2 - c1, 2);
    check("inv_next_id", id, 0);
    wait_done();
    repeat (2) @(negedge clk);
    check("inv_err_cnt", err_cnt - snap_e, 1);
    check("inv_rises", rises - snap_r, 16);
    check("inv_next_word", cap_word, 16'h8477);
    check("inv_duty", shadow_pwm_duty, 8'h77);
    check("inv_en_out", shadow_en_out, 16'h3311);
    check("inv_en_pwm", shadow_en_pwm, 16'h4422);

    // High byte then low byte of the same register
    req0_addr = 7'd1; req0_data = 8'hF0; req0_valid = 1'b1;
    wait_accept(id, c1);
    req0_addr = 7'd0; req0_data = 8'h0F; req0_valid = 1'b1;
    wait_done();
    wait_accept(id, c2);
    wait_done();
    repeat (2) @(negedge clk);
    check("hb_en_out", shadow_en_out, 16'hF00F);
    check("hb_gap_min", (last_high >= 4), 1'b1);

    // Reset during bit 7 of a frame
    snap_r = rises;
    req1_addr = 7'd2; req1_data = 8'h55; req1_valid = 1'b1;
    wait_accept(id, c1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rises - snap_r >= 8) break;
    end
    check("mid_bit7_reached", (rises - snap_r >= 8), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_ncs", ncs, 1'b1);
    check("mid_sclk", sclk, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_shadows", {shadow_en_out, shadow_en_pwm}, 32'h0);
    check("mid_duty", shadow_pwm_duty, 8'h00);
    snap_d = done_cnt;
    repeat (3) @(negedge clk);
    check("mid_no_done", done_cnt - snap_d, 0);
    rst_n = 1'b1;
    boot_frames();
    req0_addr = 7'd0; req0_data = 8'h0C; req0_valid = 1'b1;
    wait_accept(id, c1);
    wait_done();
    repeat (2) @(negedge clk);
    check("post_rst_word", cap_word, 16'h800C);
    check("post_rst_en_out", shadow_en_out, 16'h000C);
    check("post_rst_en_pwm", shadow_en_pwm, 16'h0000);

    check("done_err_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
